csr_mem_arbiter: RTL and testbench
==================================

# csr_mem_arbiter

Two-port arbiter and sequencer in front of the memory-mapped machine timer/software-interrupt register block (msip, mtime, mtimecmp). It shares the block's single rd_en/wr_en/addr/busy access port between the core data-bus requester (port 0) and the debug/DMA requester (port 1). It serialises accesses, holds address and data stable for the target, and waits out `busy`. It returns read data with a one-cycle acknowledge, using round-robin arbitration and a bounded busy timeout.

## Interface
- `BusyTimeout`, default 255: maximum WAIT cycles with `csr_busy` high before the access is aborted with error. Range 1..65535.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `reqN_rd_en` in 1 (N=0,1): read request; held high until `reqN_ack`.
- `reqN_wr_en` in 1: write request; held high until `reqN_ack`.
- `reqN_addr` in 3: register address, same encoding as the target.
- `reqN_wr_data` in `DATA_SIZE`: write data; `DATA_SIZE` is 64 under `RV64I`, else 32.
- `reqN_rd_data` out `DATA_SIZE`: read data, valid while `reqN_ack`=1.
- `reqN_ack` out 1: one-cycle completion pulse.
- `reqN_err` out 1: valid with `reqN_ack`; 1 means timeout abort.
- `reqN_lock` in 1: present only with `CSR_ARB_LOCK_EN`.
- `csr_rd_en`, `csr_wr_en` out 1: target strobes.
- `csr_addr` out 3: target address.
- `csr_wr_data` out `DATA_SIZE`: target write data.
- `csr_rd_data` in `DATA_SIZE`: target read data.
- `csr_busy` in 1: target busy.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - A port is requesting when rd_en|wr_en is high.
  - If only one port requests, it is granted.
  - If both request, the port not granted last wins. `last_grant` resets to 1, so port 0 wins first.
  - On grant, latch port id, addr, wr_data and op. If rd_en and wr_en are both high, the access is a write. Then go to ISSUE.
- **ISSUE**
  - Exactly one cycle.
  - `csr_rd_en` or `csr_wr_en` = 1 (decoded from state, not registered), with latched `csr_addr`/`csr_wr_data`.
  - Go to WAIT and clear the timeout counter.
- **WAIT**
  - Strobes = 0; `csr_addr`/`csr_wr_data` stay at latched values.
  - If `csr_busy`=0: register `csr_rd_data` (reads) or 0 (writes) into the granted port's rd_data and go to DONE.
  - If `csr_busy`=1 and counter == BusyTimeout-1: rd_data=0, err=1, go to DONE.
  - Otherwise increment the counter.
- **DONE**
  - `reqN_ack`=1 for the granted port only, for one cycle.
  - Requests are ignored this cycle. Update `last_grant` and go to IDLE.
  - The requester must drop its request by the end of the ack cycle; a request still high in IDLE is a new access.
- Outputs to the ungranted port: ack=0, err=0, rd_data=0.
- `csr_addr`/`csr_wr_data` are 0 in IDLE.
- **Reset (any state, including mid-access):** state=IDLE, `last_grant`=1, lock cleared, counter=0. All outputs read 0 in the following cycle, with no ack for the aborted access. A strobe already issued to the target is not undone.

## Timing
- Request sampled in cycle 0 (IDLE), no busy:
  - ISSUE in cycle 1, with strobe.
  - WAIT in cycle 2, sampling `csr_busy`.
  - DONE/ack in cycle 3.
  - Next arbitration in cycle 4.
- With `csr_busy` high for k consecutive WAIT cycles (k < BusyTimeout), ack moves to cycle 3+k.
- On timeout, WAIT lasts exactly BusyTimeout cycles and ack+err is in cycle 2+BusyTimeout.
- Back-to-back throughput: one access per 4 cycles.

## Configuration
- `CSR_ARB_LOCK_EN` defined:
  - `req0_lock`/`req1_lock` ports exist.
  - If the granted port has lock=1 when entering DONE, the arbiter keeps the grant. The next IDLE serves only that port, and the other port waits until the locked port completes an access with lock=0.
  - This is used by 32-bit cores to read or write mtime/mtimecmp halves atomically.
- Undefined: lock ports are absent and arbitration is pure round-robin.

## Test plan
1. **Single read, no contention.** Port 0 reads addr 3'b000; target returns 0x5, busy=0.
   - Required: `csr_rd_en`=1 in cycle 1 only, `req0_ack`=1 and `req0_rd_data`=0x5 in cycle 3, `req0_err`=0.
2. **Round-robin contention.** Both ports request in cycle 0 after reset.
   - Required: port 0 acked in cycle 3 and port 1 in cycle 7. The next simultaneous request goes to port 0 again, because `last_grant` is 1 after port 1's access.
3. **Busy stall.** Port 1 writes 0xDEADBEEF to addr 3'b011; `csr_busy`=1 in cycles 2–5.
   - Required: `csr_wr_data` stable through WAIT, `req1_ack` in cycle 7, err=0.
4. **Timeout.** BusyTimeout=8, busy stuck high.
   - Required: ack+err in cycle 10, rd_data=0, back in IDLE in cycle 11.
5. **Lock** (`CSR_ARB_LOCK_EN`). Port 0 reads 3'b010 with lock=1, then 3'b110 with lock=0, while port 1 requests continuously.
   - Required: port 0 acked in cycles 3 and 7, port 1 in cycle 11.
6. **Reset mid-access.** Assert reset in WAIT (cycle 2).
   - Required: no ack. All outputs 0 in cycle 3. A port 1 request then gets port 0 priority semantics, i.e. `last_grant`=1.

Source files
------------

// File: rtl/csr_mem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of the machine timer register block.
// Macros: RV64I selects 64-bit data; CSR_ARB_LOCK_EN adds req0_lock/req1_lock grant locking.
module csr_mem_arbiter #(
    parameter int unsigned BusyTimeout = 255,
`ifdef RV64I
    localparam int unsigned DataSize = 64
`else
    localparam int unsigned DataSize = 32
`endif
) (
    input  logic                clock,
    input  logic                reset,
`ifdef CSR_ARB_LOCK_EN
    input  logic                req0_lock,
    input  logic                req1_lock,
`endif
    input  logic                req0_rd_en,
    input  logic                req0_wr_en,
    input  logic [2:0]          req0_addr,
    input  logic [DataSize-1:0] req0_wr_data,
    output logic [DataSize-1:0] req0_rd_data,
    output logic                req0_ack,
    output logic                req0_err,
    input  logic                req1_rd_en,
    input  logic                req1_wr_en,
    input  logic [2:0]          req1_addr,
    input  logic [DataSize-1:0] req1_wr_data,
    output logic [DataSize-1:0] req1_rd_data,
    output logic                req1_ack,
    output logic                req1_err,
    output logic                csr_rd_en,
    output logic                csr_wr_en,
    output logic [2:0]          csr_addr,
    output logic [DataSize-1:0] csr_wr_data,
    input  logic [DataSize-1:0] csr_rd_data,
    input  logic                csr_busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [2:0]          addr_q, addr_d;
    logic [DataSize-1:0] wdata_q, wdata_d;
    logic [DataSize-1:0] rdata_q, rdata_d;
    logic [15:0]         cnt_q, cnt_d;
`ifdef CSR_ARB_LOCK_EN
    logic                lock_q, lock_d;
`endif
    logic                req0, req1, pick, grant;
    logic                done0, done1;

    assign req0 = req0_rd_en | req0_wr_en;
    assign req1 = req1_rd_en | req1_wr_en;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        wr_d      = wr_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
`ifdef CSR_ARB_LOCK_EN
        lock_d    = lock_q;
`endif
        pick      = 1'b0;
        grant     = 1'b0;
        csr_rd_en = 1'b0;
        csr_wr_en = 1'b0;
        unique case (state_q)
            StIdle: begin
`ifdef CSR_ARB_LOCK_EN
                // A held lock restricts service to the port that took it.
                if (lock_q) begin
                    pick  = gnt_q;
                    grant = gnt_q ? req1 : req0;
                end else
`endif
                begin
                    pick  = (req0 && req1) ? ~last_q : req1;
                    grant = req0 | req1;
                end
                if (grant) begin
                    state_d = StIssue;
                    gnt_d   = pick;
                    addr_d  = pick ? req1_addr : req0_addr;
                    wdata_d = pick ? req1_wr_data : req0_wr_data;
                    wr_d    = pick ? req1_wr_en : req0_wr_en;
                end
            end
            StIssue: begin
                csr_rd_en = ~wr_q;
                csr_wr_en = wr_q;
                cnt_d     = '0;
                state_d   = StWait;
            end
            StWait: begin
                if (!csr_busy) begin
                    rdata_d = wr_q ? '0 : csr_rd_data;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == 16'(BusyTimeout - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                last_d  = gnt_q;
`ifdef CSR_ARB_LOCK_EN
                lock_d  = gnt_q ? req1_lock : req0_lock;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
`ifdef CSR_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
`ifdef CSR_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign done0 = (state_q == StDone) && !gnt_q;
    assign done1 = (state_q == StDone) && gnt_q;

    assign req0_ack     = done0;
    assign req0_err     = done0 & err_q;
    assign req0_rd_data = done0 ? rdata_q : '0;
    assign req1_ack     = done1;
    assign req1_err     = done1 & err_q;
    assign req1_rd_data = done1 ? rdata_q : '0;

    assign csr_addr    = (state_q == StIdle) ? '0 : addr_q;
    assign csr_wr_data = (state_q == StIdle) ? '0 : wdata_q;

endmodule

// File: tb/tb_csr_mem_arbiter.sv
// Scoreboard bench for csr_mem_arbiter: random two-port traffic against a transaction-level
// model of round-robin grant order, busy stalls, timeout and mid-access reset.
module tb_csr_mem_arbiter;
`ifdef RV64I
    localparam int unsigned DW = 64;
`else
    localparam int unsigned DW = 32;
`endif
    localparam int unsigned BT = 8;

    typedef struct {
        int          port;
        int          cyc;
        logic [DW-1:0] rd;
        logic        err;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic          rq_rd [2];
    logic          rq_wr [2];
    logic [2:0]    rq_addr [2];
    logic [DW-1:0] rq_wd [2];
    logic          req0_rd_en, req0_wr_en, req1_rd_en, req1_wr_en;
    logic [2:0]    req0_addr, req1_addr, csr_addr;
    logic [DW-1:0] req0_wr_data, req1_wr_data, req0_rd_data, req1_rd_data;
    logic          req0_ack, req0_err, req1_ack, req1_err;
    logic          csr_rd_en, csr_wr_en, csr_busy;
    logic [DW-1:0] csr_wr_data, csr_rd_data;

    assign req0_rd_en   = rq_rd[0];
    assign req0_wr_en   = rq_wr[0];
    assign req0_addr    = rq_addr[0];
    assign req0_wr_data = rq_wd[0];
    assign req1_rd_en   = rq_rd[1];
    assign req1_wr_en   = rq_wr[1];
    assign req1_addr    = rq_addr[1];
    assign req1_wr_data = rq_wd[1];

    csr_mem_arbiter #(.BusyTimeout(BT)) dut (
        .clock        (clock),
        .reset        (reset),
`ifdef CSR_ARB_LOCK_EN
        .req0_lock    (1'b0),
        .req1_lock    (1'b0),
`endif
        .req0_rd_en   (req0_rd_en),
        .req0_wr_en   (req0_wr_en),
        .req0_addr    (req0_addr),
        .req0_wr_data (req0_wr_data),
        .req0_rd_data (req0_rd_data),
        .req0_ack     (req0_ack),
        .req0_err     (req0_err),
        .req1_rd_en   (req1_rd_en),
        .req1_wr_en   (req1_wr_en),
        .req1_addr    (req1_addr),
        .req1_wr_data (req1_wr_data),
        .req1_rd_data (req1_rd_data),
        .req1_ack     (req1_ack),
        .req1_err     (req1_err),
        .csr_rd_en    (csr_rd_en),
        .csr_wr_en    (csr_wr_en),
        .csr_addr     (csr_addr),
        .csr_wr_data  (csr_wr_data),
        .csr_rd_data  (csr_rd_data),
        .csr_busy     (csr_busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    // Monitor-owned model state
    exp_t          sb[$];
    logic [DW-1:0] mem [8];
    logic          mem_init = 1'b0;
    logic          m_idle = 1'b1;
    logic          m_last = 1'b1;
    logic          in_txn = 1'b0;
    logic [2:0]    txn_addr;
    logic [DW-1:0] txn_wd;
    logic [DW-1:0] cur_rd = '0;
    logic [1:0]    ack_seen = 2'b00;
    int            bs = 0;
    int            bl = 0;
    // Main-owned stimulus state
    logic          pend [2];
    logic          rand_en;
    logic          force_to;

    always @(negedge clock) begin
        logic [1:0] rq;
        logic       exp_strobe, cur_idle;
        int         p, k;
        exp_t       e;
        rq       = {rq_rd[1] | rq_wr[1], rq_rd[0] | rq_wr[0]};
        ack_seen = {req1_ack, req0_ack};
        if (!mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] = DW'({$urandom, $urandom});
            mem_init = 1'b1;
        end
        if (reset) begin
            chk("reset_ack", {req1_ack, req0_ack, req1_err, req0_err}, 0);
            chk("reset_rdata", req0_rd_data | req1_rd_data, 0);
            chk("reset_csr", {csr_rd_en, csr_wr_en, csr_addr, csr_wr_data}, 0);
            sb.delete();
            m_idle = 1'b1;
            m_last = 1'b1;
            in_txn = 1'b0;
            bl     = 0;
        end else begin
            exp_strobe = m_idle && (rq != 2'b00);
            cur_idle   = !exp_strobe && !in_txn;
            chk("strobe_timing", csr_rd_en | csr_wr_en, exp_strobe);
            if (exp_strobe) begin
                p = (rq == 2'b11) ? (m_last ? 0 : 1) : (rq[0] ? 0 : 1);
                m_last = (p == 1);
                chk("grant_op", {csr_wr_en, csr_rd_en}, rq_wr[p] ? 2'b10 : 2'b01);
                chk("grant_addr", csr_addr, rq_addr[p]);
                chk("grant_wdata", csr_wr_data, rq_wd[p]);
                case ($urandom_range(7))
                    0, 1, 2, 3: k = 0;
                    4:          k = $urandom_range(3, 1);
                    5:          k = int'(BT) - 1;
                    6:          k = int'(BT);
                    default:    k = int'(BT) + 5;
                endcase
                if (force_to) k = int'(BT) + 5;
                e.port = p;
                e.err  = (k >= int'(BT));
                e.cyc  = e.err ? cyc + 1 + int'(BT) : cyc + 2 + k;
                e.rd   = (e.err || rq_wr[p]) ? '0 : mem[rq_addr[p]];
                if (rq_wr[p]) mem[rq_addr[p]] = rq_wd[p];
                cur_rd   = mem[rq_addr[p]];
                bs       = cyc + 1;
                bl       = k;
                txn_addr = rq_addr[p];
                txn_wd   = rq_wd[p];
                in_txn   = 1'b1;
                sb.push_back(e);
            end else if (in_txn) begin
                chk("hold_addr", csr_addr, txn_addr);
                chk("hold_wdata", csr_wr_data, txn_wd);
            end
            if (cur_idle) chk("idle_csr_zero", {csr_addr, csr_wr_data}, 0);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("ack_port", {req1_ack, req0_ack}, (e.port == 1) ? 2'b10 : 2'b01);
                chk("ack_rdata", (e.port == 1) ? req1_rd_data : req0_rd_data, e.rd);
                chk("ack_err", (e.port == 1) ? req1_err : req0_err, e.err);
                chk("other_quiet", (e.port == 1) ? {req0_err, req0_rd_data}
                                                 : {req1_err, req1_rd_data}, 0);
                in_txn = 1'b0;
            end else begin
                chk("no_ack", {req1_ack, req0_ack, req1_err, req0_err}, 0);
                chk("no_rdata", req0_rd_data | req1_rd_data, 0);
            end
            m_idle = cur_idle;
        end
    end

    task automatic start(input int p, input int op, input logic [2:0] a, input logic [DW-1:0] d);
        rq_rd[p]   = (op != 1);
        rq_wr[p]   = (op != 0);
        rq_addr[p] = a;
        rq_wd[p]   = d;
        pend[p]    = 1'b1;
    endtask

    task automatic step();
        @(negedge clock);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (pend[p] && ack_seen[p]) begin
                rq_rd[p] = 1'b0;
                rq_wr[p] = 1'b0;
                pend[p]  = 1'b0;
            end else if (!pend[p] && rand_en && $urandom_range(3) == 0) begin
                start(p, $urandom_range(2), 3'($urandom_range(7)), DW'({$urandom, $urandom}));
            end
        end
        csr_busy    = (cyc >= bs) && (cyc < bs + bl);
        csr_rd_data = csr_busy ? DW'({$urandom, $urandom}) : cur_rd;
    endtask

    task automatic drain(input string nm, input int lim);
        int n = 0;
        while ((pend[0] || pend[1] || sb.size() != 0) && n < lim) begin
            step();
            n++;
        end
        chk(nm, {pend[0], pend[1], sb.size() != 0}, 0);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            rq_rd[p] = 1'b0; rq_wr[p] = 1'b0; rq_addr[p] = '0; rq_wd[p] = '0; pend[p] = 1'b0;
        end
        reset = 1'b1; rand_en = 1'b0; force_to = 1'b0; csr_busy = 1'b0; csr_rd_data = '0;
        repeat (3) step();
        reset = 1'b0;
        // Both ports request together straight after reset: port 0 first, then port 1.
        start(0, 0, 3'd0, '0);
        start(1, 1, 3'd3, DW'(32'hDEADBEEF));
        drain("drain_first", 100);
        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        drain("drain_random", 200);
        // Port 0 alone leaves the arbiter's last grant at 0.
        start(0, 1, 3'd4, DW'(32'h1234_5678));
        drain("drain_p0", 100);
        // Read on port 0, then reset while it sits in WAIT.
        force_to = 1'b1;
        start(0, 0, 3'd5, '0);
        begin
            int n = 0;
            while (!in_txn && n < 20) begin step(); n++; end
            chk("reset_test_strobe", in_txn, 1'b1);
        end
        step();
        reset = 1'b1;
        rq_rd[0] = 1'b0; rq_wr[0] = 1'b0; pend[0] = 1'b0;
        step();
        reset = 1'b0;
        force_to = 1'b0;
        repeat (6) step();
        // Contention after reset must favour port 0 again.
        start(0, 0, 3'd1, '0);
        start(1, 1, 3'd6, DW'(32'hCAFE_F00D));
        drain("drain_after_reset", 100);
        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
